// File: rtl/rx_pkt_word_packer.sv
// Packs the receiver's decoded byte stream into 32-bit AXI-Stream words
// (header, little-endian payload, status trailer) through a small output FIFO.
module rx_pkt_word_packer #(
    parameter int unsigned FIFO_ADDR_WIDTH = 3,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
    input  logic        byte_out_strobe,
    input  logic [7:0]  byte_out,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    input  logic        pkt_abort,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        drop_strobe,
    output logic [15:0] drop_count
);

    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int          CW    = FIFO_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_FLUSH,
        ST_TRAILER
    } state_t;

    logic [32:0]                mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [CW-1:0]              free;
    logic                       room3, room1;
    logic                       pop;
    logic                       push_en;
    logic [31:0]                push_data;
    logic                       push_last;
    logic [32:0]                rd_word;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dropped_q, dropped_d;
    logic        aborted_q, aborted_d;
    logic        fcs_ok_q, fcs_ok_d;
    logic        drop_pulse;
    logic        drop_strobe_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        hdr_qual;

    // Room checks use the fill level before this cycle's pop, so they are conservative.
    assign free  = DEPTH_C - count_q;
    assign room3 = (free >= CW'(3));
    assign room1 = (free >= CW'(1));

    assign m_axis_tvalid = (count_q != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign rd_word       = mem_q[rd_ptr_q];
    assign m_axis_tdata  = m_axis_tvalid ? rd_word[31:0] : 32'h0;
    assign m_axis_tlast  = m_axis_tvalid ? rd_word[32] : 1'b0;

    always_ff @(posedge s00_axi_aclk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= {push_last, push_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign hdr_qual = pkt_header_valid_strobe & pkt_header_valid;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        dropped_d  = dropped_q;
        aborted_d  = aborted_q;
        fcs_ok_d   = fcs_ok_q;
        push_en    = 1'b0;
        push_data  = 32'h0;
        push_last  = 1'b0;
        drop_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdr_qual) begin
                    if (room3) begin
                        push_en   = 1'b1;
                        push_data = {SYNC_BYTE, pkt_rate, pkt_len};
                    end else begin
                        dropped_d  = 1'b1;
                        drop_pulse = 1'b1;
                    end
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (hdr_qual) begin
                    drop_pulse = 1'b1;
                end
                if (pkt_abort) begin
                    word_d    = 32'h0;
                    aborted_d = 1'b1;
                    fcs_ok_d  = 1'b0;
                    state_d   = ST_TRAILER;
                end else begin
                    if (byte_out_strobe) begin
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0: word_d[7:0]   = byte_out;
                            2'd1: word_d[15:8]  = byte_out;
                            2'd2: word_d[23:16] = byte_out;
                            default: begin
                                word_d = 32'h0;
                                if (!dropped_q) begin
                                    if (room3) begin
                                        push_en   = 1'b1;
                                        push_data = {byte_out, word_q[23:0]};
                                    end else begin
                                        dropped_d  = 1'b1;
                                        drop_pulse = 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                    // The same-cycle byte is already folded into lane_d/dropped_d here.
                    if (fcs_out_strobe) begin
                        fcs_ok_d = fcs_ok;
                        if ((lane_d != 2'd0) && !dropped_d) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_TRAILER;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (hdr_qual) begin
                    drop_pulse = 1'b1;
                end
                if (pkt_abort) begin
                    word_d    = 32'h0;
                    aborted_d = 1'b1;
                    fcs_ok_d  = 1'b0;
                    state_d   = ST_TRAILER;
                end else if (room1) begin
                    push_en   = 1'b1;
                    push_data = word_q;
                    word_d    = 32'h0;
                    state_d   = ST_TRAILER;
                end
            end

            default: begin
                if (hdr_qual) begin
                    drop_pulse = 1'b1;
                end
                if (room1) begin
                    push_en   = 1'b1;
                    push_last = 1'b1;
                    push_data = {fcs_ok_q, aborted_q, dropped_q, 13'b0, cnt_q};
                    word_d    = 32'h0;
                    lane_d    = 2'd0;
                    cnt_d     = 16'h0;
                    dropped_d = 1'b0;
                    aborted_d = 1'b0;
                    fcs_ok_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_pulse && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q       <= ST_IDLE;
            word_q        <= 32'h0;
            lane_q        <= 2'd0;
            cnt_q         <= 16'h0;
            dropped_q     <= 1'b0;
            aborted_q     <= 1'b0;
            fcs_ok_q      <= 1'b0;
            drop_strobe_q <= 1'b0;
            drop_cnt_q    <= 16'h0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            lane_q        <= lane_d;
            cnt_q         <= cnt_d;
            dropped_q     <= dropped_d;
            aborted_q     <= aborted_d;
            fcs_ok_q      <= fcs_ok_d;
            drop_strobe_q <= drop_pulse;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign drop_strobe = drop_strobe_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_rx_pkt_word_packer.sv
// Directed bench for rx_pkt_word_packer: drives packets and compares the
// collected AXI-Stream words against hand-computed frames.
module tb_rx_pkt_word_packer;

    logic        clk;
    logic        rst_n;
    logic        hdr_stb, hdr_vld;
    logic [7:0]  rate;
    logic [15:0] len;
    logic        b_stb;
    logic [7:0]  b_dat;
    logic        fcs_stb, fcs_good;
    logic        abort;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast;
    logic        drop_stb;
    logic [15:0] drop_cnt;

    rx_pkt_word_packer #(
        .FIFO_ADDR_WIDTH(3),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .s00_axi_aclk           (clk),
        .s00_axi_aresetn        (rst_n),
        .pkt_header_valid_strobe(hdr_stb),
        .pkt_header_valid       (hdr_vld),
        .pkt_rate               (rate),
        .pkt_len                (len),
        .byte_out_strobe        (b_stb),
        .byte_out               (b_dat),
        .fcs_out_strobe         (fcs_stb),
        .fcs_ok                 (fcs_good),
        .pkt_abort              (abort),
        .m_axis_tdata           (tdata),
        .m_axis_tvalid          (tvalid),
        .m_axis_tready          (tready),
        .m_axis_tlast           (tlast),
        .drop_strobe            (drop_stb),
        .drop_count             (drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int drop_seen = 0;
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && tvalid && tready) got_q.push_back({tlast, tdata});
        if (rst_n && drop_stb) drop_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] r, input logic [15:0] l, input logic v);
        hdr_stb = 1'b1; hdr_vld = v; rate = r; len = l;
        step();
        hdr_stb = 1'b0; hdr_vld = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fcs, input logic ok);
        b_stb = 1'b1; b_dat = b; fcs_stb = fcs; fcs_good = ok;
        step();
        b_stb = 1'b0; fcs_stb = 1'b0; fcs_good = 1'b0;
    endtask

    task automatic send_fcs(input logic ok);
        fcs_stb = 1'b1; fcs_good = ok;
        step();
        fcs_stb = 1'b0; fcs_good = 1'b0;
    endtask

    task automatic send_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check_val({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        #1;
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; tready = 1'b1;
        hdr_stb = 1'b0; hdr_vld = 1'b0; rate = 8'h0; len = 16'h0;
        b_stb = 1'b0; b_dat = 8'h0; fcs_stb = 1'b0; fcs_good = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tvalid", 64'(tvalid), 64'd0);
        check_val("rst_tdata", 64'(tdata), 64'd0);
        check_val("rst_tlast", 64'(tlast), 64'd0);
        check_val("rst_drop_stb", 64'(drop_stb), 64'd0);
        check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // 8-byte good packet
        send_hdr(8'h0B, 16'd8, 1'b1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_fcs(1'b1);
        exp_q.push_back({1'b0, 32'hA50B0008});
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b0, 32'h08070605});
        exp_q.push_back({1'b1, 32'h80000008});
        drain("p8");
        check_val("p8_drop_cnt", 64'(drop_cnt), 64'd0);

        // 5-byte packet, bad FCS, flush word
        send_hdr(8'h0C, 16'd5, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_fcs(1'b0);
        exp_q.push_back({1'b0, 32'hA50C0005});
        exp_q.push_back({1'b0, 32'h44332211});
        exp_q.push_back({1'b0, 32'h00000055});
        exp_q.push_back({1'b1, 32'h00000005});
        drain("p5");

        // FCS coincident with 4th byte
        send_hdr(8'h0D, 16'd4, 1'b1);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'hDD, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 32'hA50D0004});
        exp_q.push_back({1'b0, 32'hDDCCBBAA});
        exp_q.push_back({1'b1, 32'h80000004});
        drain("p4fcs");

        // 40-byte packet into a stalled consumer
        tready = 1'b0;
        d0 = drop_seen;
        send_hdr(8'h0B, 16'd40, 1'b1);
        for (int i = 1; i <= 40; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_fcs(1'b0);
        repeat (4) step();
        check_val("stall_drop_pulses", 64'(drop_seen - d0), 64'd1);
        check_val("stall_drop_cnt", 64'(drop_cnt), 64'd1);
        check_val("stall_tvalid", 64'(tvalid), 64'd1);
        check_val("stall_tdata_hold", 64'(tdata), 64'h00000000A50B0028);
        check_val("stall_no_xfer", 64'(got_q.size()), 64'd0);
        tready = 1'b1;
        exp_q.push_back({1'b0, 32'hA50B0028});
        for (int k = 0; k < 5; k++)
            exp_q.push_back({1'b0, 8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        exp_q.push_back({1'b1, 32'h20000028});
        drain("stall");

        // Abort after 6 bytes, then a normal packet
        send_hdr(8'h0B, 16'd6, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_abort();
        exp_q.push_back({1'b0, 32'hA50B0006});
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h40000006});
        drain("abort");
        send_hdr(8'h0B, 16'd1, 1'b1);
        send_byte(8'h77, 1'b0, 1'b0);
        send_fcs(1'b1);
        exp_q.push_back({1'b0, 32'hA50B0001});
        exp_q.push_back({1'b0, 32'h00000077});
        exp_q.push_back({1'b1, 32'h80000001});
        drain("post_abort");
        check_val("abort_drop_cnt", 64'(drop_cnt), 64'd1);

        // Qualified header inside DATA is dropped, packet unaffected
        d0 = drop_seen;
        send_hdr(8'h0B, 16'd4, 1'b1);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_hdr(8'h99, 16'hFFFF, 1'b1);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_fcs(1'b1);
        exp_q.push_back({1'b0, 32'hA50B0004});
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h80000004});
        drain("hdr_in_data");
        check_val("hdr_in_data_pulses", 64'(drop_seen - d0), 64'd1);
        check_val("hdr_in_data_cnt", 64'(drop_cnt), 64'd2);

        // Unqualified header and stray bytes in IDLE are ignored
        send_hdr(8'h0B, 16'd3, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_fcs(1'b1);
        drain("idle_ignore");
        check_val("idle_ignore_cnt", 64'(drop_cnt), 64'd2);

        // Asynchronous reset mid-packet
        tready = 1'b0;
        send_hdr(8'h0B, 16'd8, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b0);
        check_val("pre_rst_tvalid", 64'(tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_tvalid", 64'(tvalid), 64'd0);
        check_val("async_rst_tdata", 64'(tdata), 64'd0);
        check_val("async_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        tready = 1'b1;
        step();
        send_hdr(8'h0B, 16'd2, 1'b1);
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        send_fcs(1'b1);
        exp_q.push_back({1'b0, 32'hA50B0002});
        exp_q.push_back({1'b0, 32'h0000E2E1});
        exp_q.push_back({1'b1, 32'h80000002});
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
